// File: rtl/bip_control.sv
// bip_control: multi-cycle control unit for the 16-bit BIP-I core.
// Latency: 3 cycles per immediate/STO/NOP instruction, 4 for LD/ADD/SUB; HLT enters HALT 2 cycles after its fetch.
// Backpressure: none; program and data memories are assumed to answer one cycle after they are addressed.
//
// Ports:
//   i_clk, i_reset      - clock and synchronous active-high reset
//   i_instr             - program-memory read data (valid one cycle after o_instr_addr)
//   o_instr_addr        - program-memory address (= PC)
//   o_data_addr         - data-memory address, IR[10:0]
//   o_operand           - IR[10:0] sign-extended to DB bits
//   o_rd_ram / o_wr_ram - data-memory read / write strobes
//   o_sel_a             - accumulator input mux (0 RAM, 1 operand, 2 ALU)
//   o_sel_b, o_op       - ALU B operand select (0 RAM, 1 operand), ALU op (0 add, 1 sub)
//   o_wr_acc            - accumulator write enable, one-cycle pulse in EXEC
//   o_halted            - high once HLT has executed, until reset
//   o_cycle_count       - only when BIP_CYCLE_COUNT_EN is defined: clocks spent outside HALT
//
// Optional feature macro: BIP_CYCLE_COUNT_EN (adds o_cycle_count and its counter).

module bip_control #(
    parameter int DB  = 16,
    parameter int PCW = 11
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [15:0]     i_instr,
    output logic [PCW-1:0]  o_instr_addr,
    output logic [10:0]     o_data_addr,
    output logic [DB-1:0]   o_operand,
    output logic            o_rd_ram,
    output logic            o_wr_ram,
    output logic [1:0]      o_sel_a,
    output logic            o_sel_b,
    output logic            o_op,
    output logic            o_wr_acc,
    output logic            o_halted
`ifdef BIP_CYCLE_COUNT_EN
    ,
    output logic [31:0]     o_cycle_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_LOAD   = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    state_t           r_state;
    state_t           w_next_state;
    logic [PCW-1:0]   r_pc;
    logic [15:0]      r_ir;
    logic [4:0]       w_ir_opcode;
    logic [4:0]       w_fetch_opcode;

    logic             w_rd_ram;
    logic             w_wr_ram;
    logic [1:0]       w_sel_a;
    logic             w_sel_b;
    logic             w_op;
    logic             w_wr_acc;

    assign w_ir_opcode    = r_ir[15:11];
    // In DECODE the IR is being loaded on this edge, so branch on the
    // memory data directly rather than the (stale) IR contents.
    assign w_fetch_opcode = i_instr[15:11];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_ir <= i_instr;
            end
            // PC advances only in EXEC; HLT never reaches EXEC, so the PC
            // stays pointing at the HLT instruction.
            if (r_state == S_EXEC) begin
                r_pc <= r_pc + PCW'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rd_ram     = 1'b0;
        w_wr_ram     = 1'b0;
        w_sel_a      = 2'd0;
        w_sel_b      = 1'b0;
        w_op         = 1'b0;
        w_wr_acc     = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                case (w_fetch_opcode)
                    OP_HLT:                 w_next_state = S_HALT;
                    OP_LD, OP_ADD, OP_SUB:  w_next_state = S_LOAD;
                    default:                w_next_state = S_EXEC;
                endcase
            end
            S_LOAD: begin
                // Address the synchronous RAM now so its data is valid in EXEC.
                w_rd_ram     = 1'b1;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                w_next_state = S_FETCH;
                case (w_ir_opcode)
                    OP_STO: begin
                        w_wr_ram = 1'b1;
                    end
                    OP_LD: begin
                        w_rd_ram = 1'b1;
                        w_wr_acc = 1'b1;
                        w_sel_a  = 2'd0;
                    end
                    OP_LDI: begin
                        w_wr_acc = 1'b1;
                        w_sel_a  = 2'd1;
                    end
                    OP_ADD: begin
                        w_rd_ram = 1'b1;
                        w_wr_acc = 1'b1;
                        w_sel_a  = 2'd2;
                    end
                    OP_ADDI: begin
                        w_wr_acc = 1'b1;
                        w_sel_a  = 2'd2;
                        w_sel_b  = 1'b1;
                    end
                    OP_SUB: begin
                        w_rd_ram = 1'b1;
                        w_wr_acc = 1'b1;
                        w_sel_a  = 2'd2;
                        w_op     = 1'b1;
                    end
                    OP_SUBI: begin
                        w_wr_acc = 1'b1;
                        w_sel_a  = 2'd2;
                        w_sel_b  = 1'b1;
                        w_op     = 1'b1;
                    end
                    default: begin
                        // Unassigned opcodes behave as NOP: no strobes.
                    end
                endcase
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign o_instr_addr = r_pc;
    assign o_data_addr  = r_ir[10:0];
    assign o_operand    = {{(DB-11){r_ir[10]}}, r_ir[10:0]};
    assign o_rd_ram     = w_rd_ram;
    assign o_wr_ram     = w_wr_ram;
    assign o_sel_a      = w_sel_a;
    assign o_sel_b      = w_sel_b;
    assign o_op         = w_op;
    assign o_wr_acc     = w_wr_acc;
    assign o_halted     = (r_state == S_HALT);

`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle_count <= '0;
        end else if (r_state != S_HALT) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign o_cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: scoreboard bench for bip_control with program/data memory and accumulator models.
// Latency: expected strobe events carry the cycle number (counted from reset release) they must appear in.
// Backpressure: none; the monitor pops one expected event per WrAcc/WrRam pulse.

module tb_bip_control;

    localparam int DB  = 16;
    localparam int PCW = 11;

    logic            i_clk;
    logic            i_reset;
    logic [15:0]     i_instr;
    logic [PCW-1:0]  o_instr_addr;
    logic [10:0]     o_data_addr;
    logic [DB-1:0]   o_operand;
    logic            o_rd_ram;
    logic            o_wr_ram;
    logic [1:0]      o_sel_a;
    logic            o_sel_b;
    logic            o_op;
    logic            o_wr_acc;
    logic            o_halted;
`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0]     o_cycle_count;
`endif

    bip_control #(.DB(DB), .PCW(PCW)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_instr      (i_instr),
        .o_instr_addr (o_instr_addr),
        .o_data_addr  (o_data_addr),
        .o_operand    (o_operand),
        .o_rd_ram     (o_rd_ram),
        .o_wr_ram     (o_wr_ram),
        .o_sel_a      (o_sel_a),
        .o_sel_b      (o_sel_b),
        .o_op         (o_op),
        .o_wr_acc     (o_wr_acc),
        .o_halted     (o_halted)
`ifdef BIP_CYCLE_COUNT_EN
        ,
        .o_cycle_count(o_cycle_count)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memories and accumulator surrounding the control unit.
    logic [15:0] pmem [0:2047];
    logic [15:0] dram [0:2047];
    logic [15:0] ram_q;
    logic [15:0] acc;
    logic [15:0] acc_in;
    logic [15:0] alu_b;

    always @(posedge i_clk) begin
        i_instr <= pmem[o_instr_addr];
        ram_q   <= dram[o_data_addr];
        if (o_wr_ram) dram[o_data_addr] <= acc;
        if (o_wr_acc) acc <= acc_in;
    end

    always_comb begin
        alu_b  = o_sel_b ? o_operand : ram_q;
        acc_in = 16'h0000;
        case (o_sel_a)
            2'd0:    acc_in = ram_q;
            2'd1:    acc_in = o_operand;
            2'd2:    acc_in = o_op ? (acc - alu_b) : (acc + alu_b);
            default: acc_in = 16'h0000;
        endcase
    end

    // Cycle number since reset release: 1 = first FETCH.
    int cyc;
    always @(posedge i_clk) begin
        if (i_reset) cyc <= 1;
        else         cyc <= cyc + 1;
    end

    int n_chk;
    int n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int          cyc;
        logic        wa;
        logic        wr;
        logic [1:0]  sa;
        logic        sb;
        logic        op;
        logic        rd;
        logic [15:0] opnd;
        logic [10:0] da;
        logic [15:0] val;
    } ev_t;

    ev_t exp_q[$];

    task automatic push(input int c, input logic wa, input logic wr, input logic [1:0] sa,
                        input logic sb, input logic op, input logic rd,
                        input logic [15:0] opnd, input logic [10:0] da, input logic [15:0] val);
        ev_t e;
        e.cyc = c; e.wa = wa; e.wr = wr; e.sa = sa; e.sb = sb; e.op = op;
        e.rd = rd; e.opnd = opnd; e.da = da; e.val = val;
        exp_q.push_back(e);
    endtask

    // Monitor: every WrAcc/WrRam pulse must match the next expected event.
    always @(negedge i_clk) begin
        if (o_wr_acc || o_wr_ram) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, o_wr_acc, o_wr_ram}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_cycle",   cyc, e.cyc);
                chk("ev_strobes", {27'd0, o_wr_acc, o_wr_ram, o_sel_a, o_sel_b, o_op, o_rd_ram},
                                  {27'd0, e.wa, e.wr, e.sa, e.sb, e.op, e.rd});
                chk("ev_operand", {16'd0, o_operand}, {16'd0, e.opnd});
                chk("ev_daddr",   {21'd0, o_data_addr}, {21'd0, e.da});
                chk("ev_value",   {16'd0, (o_wr_acc ? acc_in : acc)}, {16'd0, e.val});
            end
        end
    end

    task automatic wait_cyc(input int n);
        int k;
        k = 0;
        while (cyc != n && k < 20000) begin
            @(negedge i_clk);
            k++;
        end
        if (cyc != n) chk("wait_timeout", cyc, n);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
    endtask

    initial begin
        int bad;
        n_chk   = 0;
        n_pass  = 0;
        i_reset = 1'b1;
        acc     = 16'h0000;
        for (int i = 0; i < 2048; i++) begin
            pmem[i] = 16'h0000;
            dram[i] = 16'h0000;
        end
        dram[3] = 16'h0001;
        dram[4] = 16'h1234;

        // Program 1: straight-line exercise of every opcode class.
        pmem[0] = 16'h1805;   // LDI 5
        pmem[1] = 16'h2FFF;   // ADDI 0x7FF (-1)
        pmem[2] = 16'h3003;   // SUB [3]
        pmem[3] = 16'h1004;   // LD [4]
        pmem[4] = 16'h2003;   // ADD [3]
        pmem[5] = 16'h3FFE;   // SUBI 0x7FE (-2)
        pmem[6] = 16'h4000;   // NOP (opcode 01000)
        pmem[7] = 16'h0807;   // STO [7]
        pmem[8] = 16'h0000;   // HLT

        push( 3, 1, 0, 2'd1, 0, 0, 0, 16'h0005, 11'h005, 16'h0005);
        push( 6, 1, 0, 2'd2, 1, 0, 0, 16'hFFFF, 11'h7FF, 16'h0004);
        push(10, 1, 0, 2'd2, 0, 1, 1, 16'h0003, 11'h003, 16'h0003);
        push(14, 1, 0, 2'd0, 0, 0, 1, 16'h0004, 11'h004, 16'h1234);
        push(18, 1, 0, 2'd2, 0, 0, 1, 16'h0003, 11'h003, 16'h1235);
        push(21, 1, 0, 2'd2, 1, 1, 0, 16'hFFFE, 11'h7FE, 16'h1237);
        push(27, 0, 1, 2'd0, 0, 0, 0, 16'h0007, 11'h007, 16'h1237);

        @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_state", {16'd0, 5'd0, o_instr_addr},          32'd0);
        chk("reset_strobes", {26'd0, o_wr_acc, o_wr_ram, o_rd_ram, o_sel_a, o_halted}, 32'd0);
        do_reset();

        wait_cyc(1);  chk("c1_iaddr", {21'd0, o_instr_addr}, 32'd0);
        wait_cyc(4);  chk("c4_iaddr", {21'd0, o_instr_addr}, 32'd1);
        wait_cyc(8);  chk("sub_decode_rd", {31'd0, o_rd_ram}, 32'd0);
        wait_cyc(9);
        chk("sub_load_rd", {20'd0, o_rd_ram, o_data_addr}, {20'd0, 1'b1, 11'd3});
        chk("sub_load_quiet", {28'd0, o_wr_acc, o_sel_b, o_op, o_wr_ram}, 32'd0);
        wait_cyc(11); chk("sub_4cycles_iaddr", {21'd0, o_instr_addr}, 32'd3);
        wait_cyc(24); chk("nop_exec_quiet", {29'd0, o_wr_acc, o_wr_ram, o_rd_ram}, 32'd0);
        wait_cyc(25); chk("nop_iaddr", {21'd0, o_instr_addr}, 32'd7);
        wait_cyc(28); chk("sto_ram", {16'd0, dram[7]}, 32'h1237);
        wait_cyc(29); chk("halt_not_yet", {31'd0, o_halted}, 32'd0);
        wait_cyc(30); chk("halted", {31'd0, o_halted}, 32'd1);
`ifdef BIP_CYCLE_COUNT_EN
        chk("cc_at_halt", o_cycle_count, 32'd29);
`endif
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_halted !== 1'b1 || o_wr_acc !== 1'b0 || o_wr_ram !== 1'b0 ||
                o_rd_ram !== 1'b0 || o_sel_a !== 2'd0 || o_sel_b !== 1'b0 ||
                o_op !== 1'b0 || o_instr_addr !== 11'd8) bad++;
        end
        chk("halt_quiet_100", bad, 0);
`ifdef BIP_CYCLE_COUNT_EN
        chk("cc_frozen", o_cycle_count, 32'd29);
`endif

        // Program 2: reset during the EXEC cycle of an ADD aborts it.
        pmem[0] = 16'h2003;   // ADD [3]
        pmem[1] = 16'h0000;   // HLT
        push(4, 1, 0, 2'd2, 0, 0, 1, 16'h0003, 11'h003, 16'h1238);
        push(4, 1, 0, 2'd2, 0, 0, 1, 16'h0003, 11'h003, 16'h1239);
        do_reset();
        wait_cyc(4);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        chk("abort_iaddr", {21'd0, o_instr_addr}, 32'd0);
        chk("abort_strobes", {27'd0, o_wr_acc, o_rd_ram, o_sel_a, o_halted}, 32'd0);
`ifdef BIP_CYCLE_COUNT_EN
        chk("abort_cc", o_cycle_count, 32'd0);
`endif
        wait_cyc(7);
        chk("run2_halted", {31'd0, o_halted}, 32'd1);
        chk("run2_iaddr", {21'd0, o_instr_addr}, 32'd1);

        // Program 3: all NOPs, PC must wrap from 2047 to 0.
        for (int i = 0; i < 2048; i++) pmem[i] = 16'hF800;
        do_reset();
        wait_cyc(6142); chk("wrap_last", {21'd0, o_instr_addr}, 32'd2047);
        wait_cyc(6145); chk("wrap_zero", {21'd0, o_instr_addr}, 32'd0);
        wait_cyc(6148); chk("wrap_one", {21'd0, o_instr_addr}, 32'd1);
        chk("wrap_not_halted", {31'd0, o_halted}, 32'd0);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
